// File: rtl/backprop_out_delta_if.sv
// rtl/backprop_out_delta_if.sv - request/result bundle for the output-layer delta engine
//
// Signals:
//   start      : request to process one vector (sampled only when idle)
//   nabla_loss : cost gradient, neuron k at bits [N*W-1-W*k -: W]
//   dactiv     : activation derivative, neuron k at bits [W*k +: W]
//   delta_out  : output-layer error, neuron k at bits [W*k +: W]
//   busy       : a vector is in progress
//   done       : one-cycle pulse when delta_out is complete
//   sat        : some element of the last run saturated
// Modports: master drives the request side, slave is the engine.
`timescale 1ns/1ps
interface backprop_out_delta_if #(
    parameter int N = 10,
    parameter int W = 32
);
    logic           start;
    logic [N*W-1:0] nabla_loss;
    logic [N*W-1:0] dactiv;
    logic [N*W-1:0] delta_out;
    logic           busy;
    logic           done;
    logic           sat;

    modport master (
        output start, nabla_loss, dactiv,
        input  delta_out, busy, done, sat
    );

    modport slave (
        input  start, nabla_loss, dactiv,
        output delta_out, busy, done, sat
    );
endinterface

// File: rtl/backprop_out_delta.sv
// rtl/backprop_out_delta.sv - output-layer delta = nabla_loss * dactiv, Q8.24, one element per cycle
//
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high; clears state, flags and delta_out
//   bus   : backprop_out_delta_if.slave (start, nabla_loss, dactiv in;
//           delta_out, busy, done, sat out)
// A single signed multiplier is shared over the N elements. Operands are
// captured on the accepting edge so the run is immune to later input changes.
`timescale 1ns/1ps
module backprop_out_delta #(
    parameter int N = 10,
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    backprop_out_delta_if.slave  bus
);
    localparam int FRAC = 24;
    localparam int IW   = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  nabla_q  [N];
    logic [W-1:0]  dactiv_q [N];
    logic [W-1:0]  delta_q  [N];
    logic          busy_q;
    logic          done_q;
    logic          sat_q;

    // Shared multiplier: operands sign-extended to full product width so the
    // low 2W bits of the multiply are the exact signed product.
    logic [W-1:0]          op_a;
    logic [W-1:0]          op_b;
    logic signed [2*W-1:0] op_a_ext;
    logic signed [2*W-1:0] op_b_ext;
    logic signed [2*W-1:0] prod;
    logic [2*W-FRAC-W:0]   prod_top;
    logic                  ovf_d;
    logic [W-1:0]          word_d;

    assign op_a     = nabla_q[idx_q];
    assign op_b     = dactiv_q[idx_q];
    assign op_a_ext = {{W{op_a[W-1]}}, op_a};
    assign op_b_ext = {{W{op_b[W-1]}}, op_b};
    assign prod     = op_a_ext * op_b_ext;

    // Result keeps product bits [FRAC+W-1:FRAC]; it is representable only if
    // every bit from the kept sign bit upward agrees.
    assign prod_top = prod[2*W-1:FRAC+W-1];

    always_comb begin
        ovf_d  = !((&prod_top) || !(|prod_top));
        word_d = prod[FRAC+W-1:FRAC];
        if (ovf_d) begin
            word_d = prod[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            for (int k = 0; k < N; k++) begin
                nabla_q[k]  <= '0;
                dactiv_q[k] <= '0;
                delta_q[k]  <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        // nabla_loss is packed with neuron 0 in the top word,
                        // dactiv with neuron 0 in the bottom word.
                        for (int k = 0; k < N; k++) begin
                            nabla_q[k]  <= bus.nabla_loss[(N-1-k)*W +: W];
                            dactiv_q[k] <= bus.dactiv[k*W +: W];
                        end
                        idx_q   <= '0;
                        sat_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    delta_q[idx_q] <= word_d;
                    sat_q          <= sat_q | ovf_d;
                    if (idx_q == IW'(N-1)) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign bus.delta_out[g*W +: W] = delta_q[g];
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sat  = sat_q;
endmodule

// File: tb/tb_backprop_out_delta.sv
// tb/tb_backprop_out_delta.sv - scoreboard bench for backprop_out_delta
`timescale 1ns/1ps
module tb_backprop_out_delta;
    logic clk;
    logic reset;

    backprop_out_delta_if #(.N(10), .W(32)) bus ();

    backprop_out_delta #(.N(10), .W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [319:0] delta;
        logic         sat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] nab [10];
    logic [31:0] dac [10];

    task automatic apply_inputs();
        for (int k = 0; k < 10; k++) begin
            bus.nabla_loss[(9-k)*32 +: 32] = nab[k];
            bus.dactiv[k*32 +: 32]         = dac[k];
        end
    endtask

    task automatic fill_inputs(input logic [31:0] n, input logic [31:0] d);
        for (int k = 0; k < 10; k++) begin
            nab[k] = n;
            dac[k] = d;
        end
    endtask

    // Reference: exact product, floor-divided by 2^24, clamped to 32-bit range.
    function automatic logic [32:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        longint q;
        p = longint'($signed(a)) * longint'($signed(b));
        q = p >>> 24;
        if (q > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
        if (q < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        return {1'b0, q[31:0]};
    endfunction

    task automatic push_model();
        exp_t        e;
        logic [32:0] r;
        e.delta = '0;
        e.sat   = 1'b0;
        for (int k = 0; k < 10; k++) begin
            r = model_mul(nab[k], dac[k]);
            e.delta[k*32 +: 32] = r[31:0];
            e.sat = e.sat | r[32];
        end
        sb.push_back(e);
    endtask

    task automatic push_const(input logic [319:0] d, input logic s);
        exp_t e;
        e.delta = d;
        e.sat   = s;
        sb.push_back(e);
    endtask

    // Drives start for one edge (edge T); returns at the falling edge after T.
    task automatic start_run(input string tag);
        @(negedge clk);
        apply_inputs();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_at_T got %b want 1", tag, bus.busy);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic scoreboard_check(input string tag);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard_empty got 0 entries want 1", tag);
            return;
        end
        e = sb.pop_front();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (bus.delta_out[k*32 +: 32] !== e.delta[k*32 +: 32]) begin
                errors++;
                $display("FAIL %s delta[%0d] got %h want %h", tag, k,
                         bus.delta_out[k*32 +: 32], e.delta[k*32 +: 32]);
            end
        end
        checks++;
        if (bus.sat !== e.sat) begin
            errors++;
            $display("FAIL %s sat got %b want %b", tag, bus.sat, e.sat);
        end
    endtask

    // Waits (bounded) for done, checks latency, busy throughout, results and the
    // return to idle on the following edge.
    task automatic finish_run(input string tag, input int exp_lat);
        int cyc  = 0;
        bit seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy_in_run cycle %0d got %b want 1", tag, i, bus.busy);
            end
            if (bus.done === 1'b1) begin
                cyc  = i;
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || cyc != exp_lat) begin
            errors++;
            $display("FAIL %s done_latency got %0d (seen %0b) want %0d", tag, cyc, seen, exp_lat);
        end
        scoreboard_check(tag);
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done got done=%b busy=%b want 0 0", tag, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sat !== 1'b0 || bus.delta_out !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b sat=%b delta=%h want all 0",
                     bus.busy, bus.done, bus.sat, bus.delta_out);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_start got done=%b busy=%b want 0 0", bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_quarter();
        fill_inputs(32'h0100_0000, 32'h0040_0000);
        push_const({10{32'h0040_0000}}, 1'b0);
        start_run("quarter");
        finish_run("quarter", 10);
    endtask

    task automatic test_negative();
        fill_inputs(32'hFE00_0000, 32'h0080_0000);
        push_const({10{32'hFF00_0000}}, 1'b0);
        start_run("negative");
        finish_run("negative", 10);
    endtask

    task automatic test_saturation();
        logic [319:0] e;
        fill_inputs(32'h0, 32'h0);
        nab[3] = 32'h6400_0000;
        dac[3] = 32'h0400_0000;
        e = '0;
        e[96 +: 32] = 32'h7FFF_FFFF;
        push_const(e, 1'b1);
        start_run("sat_pos");
        finish_run("sat_pos", 10);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold got %b want 1", bus.sat);
        end
        nab[3] = 32'h9C00_0000;
        e[96 +: 32] = 32'h8000_0000;
        push_const(e, 1'b1);
        start_run("sat_neg");
        finish_run("sat_neg", 10);
    endtask

    // New run after a saturating one: sat clears at accept, unwritten words keep old values.
    task automatic test_partial_hold();
        fill_inputs(32'h0100_0000, 32'h0100_0000);
        push_const({10{32'h0100_0000}}, 1'b0);
        start_run("partial");
        checks++;
        if (bus.sat !== 1'b0) begin
            errors++;
            $display("FAIL partial sat_cleared got %b want 0", bus.sat);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.delta_out[0 +: 32] !== 32'h0100_0000 || bus.delta_out[96 +: 32] !== 32'h8000_0000) begin
            errors++;
            $display("FAIL partial mid_run got w0=%h w3=%h want 01000000 80000000",
                     bus.delta_out[0 +: 32], bus.delta_out[96 +: 32]);
        end
        finish_run("partial", 7);
    endtask

    task automatic test_ordering();
        fill_inputs(32'h0, 32'h0100_0000);
        nab[0] = 32'h0100_0000;
        push_const({288'h0, 32'h0100_0000}, 1'b0);
        start_run("ordering");
        finish_run("ordering", 10);
    endtask

    task automatic test_mid_reset();
        int pulses = 0;
        fill_inputs(32'h0100_0000, 32'h0100_0000);
        nab[0] = 32'h6400_0000;
        dac[0] = 32'h0400_0000;
        start_run("mid_reset");
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus.sat !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset pre got sat=%b busy=%b want 1 1", bus.sat, bus.busy);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sat !== 1'b0 || bus.delta_out !== '0) begin
            errors++;
            $display("FAIL mid_reset async got busy=%b done=%b sat=%b delta=%h want all 0",
                     bus.busy, bus.done, bus.sat, bus.delta_out);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset no_done got pulses=%0d busy=%b want 0 0", pulses, bus.busy);
        end
        fill_inputs(32'h0100_0000, 32'h0040_0000);
        push_const({10{32'h0040_0000}}, 1'b0);
        start_run("after_reset");
        finish_run("after_reset", 10);
    endtask

    task automatic test_ignored_start();
        int pulses = 0;
        for (int k = 0; k < 10; k++) begin
            nab[k] = 32'h0080_0000 + 32'(k) * 32'h0011_0000;
            dac[k] = 32'hFFC0_0000 - 32'(k) * 32'h0003_0000;
        end
        push_model();
        start_run("ignored");
        repeat (3) @(posedge clk);
        @(negedge clk);
        fill_inputs(32'h7000_0000, 32'h7000_0000);
        apply_inputs();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL ignored at_T4 got busy=%b done=%b want 1 0", bus.busy, bus.done);
        end
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL ignored done_pulses got %0d want 1", pulses);
        end
        scoreboard_check("ignored");
    endtask

    // Start held through the DONE cycle: ignored there, accepted on the next edge.
    task automatic test_back_to_back();
        int cyc  = 0;
        bit seen = 1'b0;
        fill_inputs(32'hFF80_0000, 32'h0200_0000);
        push_model();
        start_run("b2b_a");
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                cyc  = i;
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || cyc != 10) begin
            errors++;
            $display("FAIL b2b_a done_latency got %0d (seen %0b) want 10", cyc, seen);
        end
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            nab[k] = $urandom();
            dac[k] = 32'($signed($urandom()) >>> $urandom_range(2, 12));
        end
        push_model();
        apply_inputs();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b start_in_done got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b accept_T12 got busy=%b want 1", bus.busy);
        end
        scoreboard_check("b2b_a");
        @(negedge clk);
        bus.start = 1'b0;
        finish_run("b2b_b", 10);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 10; k++) begin
                nab[k] = $urandom();
                dac[k] = 32'($signed($urandom()) >>> $urandom_range(4, 14));
            end
            push_model();
            start_run("random");
            finish_run("random", 10);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.nabla_loss = '0;
        bus.dactiv     = '0;
        test_reset();
        test_quarter();
        test_negative();
        test_saturation();
        test_partial_hold();
        test_ordering();
        test_mid_reset();
        test_ignored_start();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/backprop_out_delta.md
BACKPROP_OUT_DELTA -- requirements
Module: backprop_out_delta

Interface
REQ-001 SHALL have parameter N, default 10, meaning output-layer neuron count; fixed at 10 for this release.
REQ-002 SHALL have parameter W, default 32, meaning word width in signed Q8.24.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to process one vector; sampled only in IDLE.
REQ-006 SHALL have port nabla_loss  input  320  cost gradient; neuron k at bits [319-32k : 288-32k].
REQ-007 SHALL have port dactiv  input  320  activation derivative; neuron k at bits [32k+31 : 32k].
REQ-008 SHALL have port delta_out  output  320  output-layer error; neuron k at bits [32k+31 : 32k].
REQ-009 SHALL have port busy  output  1  high while a vector is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when delta_out is complete.
REQ-011 SHALL have port sat  output  1  high if any element of the last run saturated.

Function
REQ-012 SHALL compute delta_out[k] = nabla_loss[k] * dactiv[k] in Q8.24 for k = 0..9.
REQ-013 SHALL use a single 32x32 signed multiplier, time-shared, one element per cycle.
REQ-014 SHALL form each result from the 64-bit product as bits [55:24] (truncation toward minus infinity).
REQ-015 SHALL saturate when product bits [63:55] are not all equal: positive -> 0x7FFFFFFF, negative -> 0x80000000.
REQ-016 SHALL implement states IDLE, RUN, DONE.
REQ-017 IDLE: start=1 at edge T SHALL latch nabla_loss and dactiv, clear idx and sat, and enter RUN; busy=1 from T.
REQ-018 RUN: each edge SHALL write delta_out[idx] and increment idx; the write at idx=9 (edge T+10) SHALL enter DONE.
REQ-019 DONE: done=1 and busy=1 for exactly one cycle; next edge SHALL return to IDLE with busy=0.
REQ-020 Latency: done SHALL be high in the cycle following edge T+10; the next start SHALL be accepted no earlier than edge T+12.
REQ-021 start in RUN or DONE SHALL be ignored; no queueing.
REQ-022 Input changes after edge T SHALL NOT affect the run in progress.
REQ-023 delta_out SHALL hold its final value from DONE until the next accepted start; elements not yet written in a new run SHALL keep prior values.
REQ-024 sat SHALL be the OR of all saturation events of the current run and SHALL hold until the next accepted start.
REQ-025 done SHALL never assert without a preceding accepted start.

Reset
REQ-026 reset=1 SHALL immediately, without clock, force state IDLE, idx=0, busy=0, done=0, sat=0, delta_out=0.
REQ-027 reset asserted mid-run SHALL abort the run; no done pulse SHALL follow.
REQ-028 After reset deassertion, the first rising edge with start=1 SHALL begin a run normally.

Verification
REQ-029 All nabla=0x01000000 (1.0), all dactiv=0x00400000 (0.25), start pulse -> every delta_out word 0x00400000, sat=0, done one cycle after edge T+10, busy high T..done.
REQ-030 All nabla=0xFE000000 (-2.0), all dactiv=0x00800000 (0.5) -> every word 0xFF000000 (-1.0), sat=0.
REQ-031 nabla[3]=0x64000000 (100.0), dactiv[3]=0x04000000 (4.0), others 0 -> delta_out[3]=0x7FFFFFFF, sat=1, other words 0; repeat with nabla[3]=0x9C000000 -> 0x80000000.
REQ-032 Ordering: only nabla bits [319:288]=0x01000000, all dactiv=0x01000000 -> delta_out[31:0]=0x01000000, all other words 0.
REQ-033 Assert reset at edge T+5 -> busy, done, sat, delta_out all 0 at once, no done pulse; a fresh start then completes with correct values.
REQ-034 Second start pulse at edge T+4 with different inputs -> ignored; results match the first vector; exactly one done pulse.
